// File: rtl/csr_trap_unit_if.sv
// Instruction-side CSR/trap bundle: the decoder drives requests, the CSR unit answers
// with read data and the redirect controls.
interface csr_trap_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic [1:0]  csr_op;
  logic        csr_source;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        exc_ret;
  logic [31:0] csr_rdata;
  logic        exception_present;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        illegal_csr;

  modport master (
    output instr_valid, pc, csr_op, csr_source, csr_addr, rs1_data, zimm,
           exc_request, exc_cause, exc_ret,
    input  csr_rdata, exception_present, mtvec_out, mepc_out, illegal_csr
  );

  modport slave (
    input  instr_valid, pc, csr_op, csr_source, csr_addr, rs1_data, zimm,
           exc_request, exc_cause, exc_ret,
    output csr_rdata, exception_present, mtvec_out, mepc_out, illegal_csr
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle RV32I core.
// Reads are combinational; every CSR, trap and counter update commits at the clock edge.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_timer,
  input  logic irq_ext,
  csr_trap_unit_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
  localparam logic [31:0] CAUSE_IRQ_TMR  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT  = 32'h8000_000B;

  logic        mstatusMie;
  logic        mstatusMpie;
  logic        mieMtie;
  logic        mieMeie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mscratch;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] operand;
  logic [31:0] oldValue;
  logic [31:0] newValue;
  logic [31:0] trapCause;
  logic        opActive;
  logic        isWriteOp;
  logic        supported;
  logic        readOnly;
  logic        illegal;
  logic        irqExtPend;
  logic        irqTmrPend;
  logic        trapTaken;
  logic        mretTaken;
  logic        csrWrite;
  logic        retire;

  assign operand   = bus.csr_source ? {27'b0, bus.zimm} : bus.rs1_data;
  assign opActive  = (bus.csr_op != 2'd0);
  // Set/clear with a zero operand is a pure read, so it may touch read-only CSRs.
  assign isWriteOp = (bus.csr_op == 2'd1) || (bus.csr_op[1] && (operand != '0));
  assign readOnly  = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == ADDR_MISA)
                  || (bus.csr_addr == ADDR_MIP);

  always_comb begin
    oldValue  = '0;
    supported = 1'b1;
    case (bus.csr_addr)
      ADDR_MSTATUS:   oldValue = {19'b0, 2'b11, 3'b0, mstatusMpie, 3'b0, mstatusMie, 3'b0};
      ADDR_MISA:      oldValue = MISA_VALUE;
      ADDR_MIE:       oldValue = {20'b0, mieMeie, 3'b0, mieMtie, 7'b0};
      ADDR_MTVEC:     oldValue = mtvec;
      ADDR_MSCRATCH:  oldValue = mscratch;
      ADDR_MEPC:      oldValue = mepc;
      ADDR_MCAUSE:    oldValue = mcause;
      ADDR_MIP:       oldValue = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
      ADDR_MCYCLE:    oldValue = mcycle[31:0];
      ADDR_MINSTRET:  oldValue = minstret[31:0];
      ADDR_MCYCLEH:   oldValue = mcycle[63:32];
      ADDR_MINSTRETH: oldValue = minstret[63:32];
      ADDR_MHARTID:   oldValue = HART_ID;
      default:        supported = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.csr_op)
      2'd1:    newValue = operand;
      2'd2:    newValue = oldValue | operand;
      2'd3:    newValue = oldValue & ~operand;
      default: newValue = oldValue;
    endcase
  end

  assign illegal    = bus.instr_valid && opActive && (!supported || (isWriteOp && readOnly));
  assign irqExtPend = mstatusMie && mieMeie && irq_ext;
  assign irqTmrPend = mstatusMie && mieMtie && irq_timer;
  assign trapTaken  = bus.instr_valid && (irqExtPend || irqTmrPend || bus.exc_request || illegal);
  assign mretTaken  = bus.instr_valid && bus.exc_ret && !trapTaken;
  assign csrWrite   = bus.instr_valid && opActive && isWriteOp && !trapTaken && !bus.exc_ret;
  assign retire     = bus.instr_valid && !trapTaken;

  always_comb begin
    if (irqExtPend)           trapCause = CAUSE_IRQ_EXT;
    else if (irqTmrPend)      trapCause = CAUSE_IRQ_TMR;
    else if (bus.exc_request) trapCause = bus.exc_cause;
    else                      trapCause = CAUSE_ILLEGAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatusMie  <= 1'b0;
      mstatusMpie <= 1'b0;
      mieMtie     <= 1'b0;
      mieMeie     <= 1'b0;
      mtvec       <= MTVEC_RESET & ~32'h3;
      mepc        <= '0;
      mcause      <= '0;
      mscratch    <= '0;
      mcycle      <= '0;
      minstret    <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (retire) minstret <= minstret + 64'd1;
      if (trapTaken) begin
        mepc        <= bus.pc & ~32'h3;
        mcause      <= trapCause;
        mstatusMpie <= mstatusMie;
        mstatusMie  <= 1'b0;
      end else if (mretTaken) begin
        mstatusMie  <= mstatusMpie;
        mstatusMpie <= 1'b1;
      end else if (csrWrite) begin
        // Counter half-writes override the increment above; the other half is frozen.
        case (bus.csr_addr)
          ADDR_MSTATUS: begin
            mstatusMie  <= newValue[3];
            mstatusMpie <= newValue[7];
          end
          ADDR_MIE: begin
            mieMtie <= newValue[7];
            mieMeie <= newValue[11];
          end
          ADDR_MTVEC:     mtvec    <= newValue & ~32'h3;
          ADDR_MSCRATCH:  mscratch <= newValue;
          ADDR_MEPC:      mepc     <= newValue & ~32'h3;
          ADDR_MCAUSE:    mcause   <= newValue;
          ADDR_MCYCLE:    mcycle   <= {mcycle[63:32], newValue};
          ADDR_MCYCLEH:   mcycle   <= {newValue, mcycle[31:0]};
          ADDR_MINSTRET:  minstret <= {minstret[63:32], newValue};
          ADDR_MINSTRETH: minstret <= {newValue, minstret[31:0]};
          default: ;
        endcase
      end
    end
  end

  assign bus.csr_rdata         = opActive ? oldValue : '0;
  assign bus.exception_present = trapTaken;
  assign bus.illegal_csr       = illegal;
  assign bus.mtvec_out         = mtvec;
  assign bus.mepc_out          = mepc;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expectations are queued as each step is driven
// and drained against the DUT outputs on the falling edge of that cycle.
module tb_csr_trap_unit;
  localparam int unsigned SEL_RDATA = 0;
  localparam int unsigned SEL_EXC   = 1;
  localparam int unsigned SEL_ILL   = 2;
  localparam int unsigned SEL_MTVEC = 3;
  localparam int unsigned SEL_MEPC  = 4;

  logic clk = 1'b0;
  logic rst;
  logic irq_timer;
  logic irq_ext;

  csr_trap_unit_if bus ();

  csr_trap_unit #(
    .MTVEC_RESET(32'h0000_0100),
    .MISA_VALUE (32'h4000_0100),
    .HART_ID    (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_timer(irq_timer),
    .irq_ext  (irq_ext),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned qSel[$];
  logic [31:0] qExp[$];
  string       qTag[$];
  logic [63:0] instret     = '0;
  logic        lastRetire  = 1'b0;

  task automatic want(input int unsigned sel, input logic [31:0] exp, input string tag);
    qSel.push_back(sel);
    qExp.push_back(exp);
    qTag.push_back(tag);
  endtask

  task automatic flags(input logic exc, input logic ill, input string tag);
    want(SEL_EXC, {31'b0, exc}, {tag, ".exc"});
    want(SEL_ILL, {31'b0, ill}, {tag, ".ill"});
  endtask

  task automatic drive(input logic v, input logic [31:0] pcv, input logic [1:0] op,
                       input logic src, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] z, input logic er, input logic [31:0] ec,
                       input logic ret, input logic expTrap);
    bus.instr_valid = v;
    bus.pc          = pcv;
    bus.csr_op      = op;
    bus.csr_source  = src;
    bus.csr_addr    = addr;
    bus.rs1_data    = rs1;
    bus.zimm        = z;
    bus.exc_request = er;
    bus.exc_cause   = ec;
    bus.exc_ret     = ret;
    lastRetire      = v && !expTrap;
  endtask

  task automatic idle();
    drive(1'b0, '0, 2'd0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // CSRRS rd, addr, x0: read without side effects other than retiring.
  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    drive(1'b1, 32'h200, 2'd2, 1'b0, addr, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    want(SEL_RDATA, exp, tag);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] val);
    drive(1'b1, 32'h200, op, 1'b0, addr, val, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic setMie();
    drive(1'b1, 32'h200, 2'd2, 1'b1, 12'h300, '0, 5'd8, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkAll();
    int unsigned sel;
    logic [31:0] exp;
    logic [31:0] obs;
    string       tag;
    while (qSel.size() > 0) begin
      sel = qSel.pop_front();
      exp = qExp.pop_front();
      tag = qTag.pop_front();
      case (sel)
        SEL_RDATA: obs = bus.csr_rdata;
        SEL_EXC:   obs = {31'b0, bus.exception_present};
        SEL_ILL:   obs = {31'b0, bus.illegal_csr};
        SEL_MTVEC: obs = bus.mtvec_out;
        default:   obs = bus.mepc_out;
      endcase
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    if (rst) instret = '0;
    else if (lastRetire) instret = instret + 64'd1;
    #1;
  endtask

  initial begin
    rst = 1'b1; irq_timer = 1'b0; irq_ext = 1'b0;
    idle(); tick(); tick();
    rst = 1'b0;

    idle(); flags(1'b0, 1'b0, "reset");
    want(SEL_MTVEC, 32'h100, "reset.mtvec"); want(SEL_MEPC, 32'h0, "reset.mepc");
    want(SEL_RDATA, 32'h0, "reset.rdata"); tick();

    wr(2'd1, 12'h305, 32'h203); want(SEL_RDATA, 32'h100, "mtvec.old");
    flags(1'b0, 1'b0, "csrrw"); tick();
    rd(12'h305, 32'h200, "mtvec.rd"); want(SEL_MTVEC, 32'h200, "mtvec.out"); tick();
    setMie(); want(SEL_RDATA, 32'h1800, "mstatus.old"); tick();
    rd(12'h300, 32'h1808, "mstatus.mie1"); tick();

    drive(1'b1, 32'h82, 2'd0, 1'b0, '0, '0, '0, 1'b1, 32'd11, 1'b0, 1'b1);
    flags(1'b1, 1'b0, "ecall"); tick();
    rd(12'h341, 32'h80, "ecall.mepc"); want(SEL_MEPC, 32'h80, "ecall.mepcOut"); tick();
    rd(12'h342, 32'd11, "ecall.mcause"); tick();
    rd(12'h300, 32'h1880, "ecall.mstatus"); tick();
    rd(12'hB02, instret[31:0], "ecall.minstret"); tick();

    wr(2'd1, 12'h304, 32'hFFFF_FFFF); tick();
    rd(12'h304, 32'h880, "mie.mask"); tick();
    setMie(); tick();
    irq_timer = 1'b1; irq_ext = 1'b1;
    drive(1'b1, 32'h104, 2'd0, 1'b0, '0, '0, '0, 1'b1, 32'd3, 1'b0, 1'b1);
    flags(1'b1, 1'b0, "irq"); tick();
    rd(12'h342, 32'h8000_000B, "irq.mcause"); want(SEL_MEPC, 32'h104, "irq.mepc"); tick();
    rd(12'h300, 32'h1880, "irq.mstatus"); tick();
    rd(12'h344, 32'h880, "mip"); tick();
    irq_timer = 1'b0; irq_ext = 1'b0;
    drive(1'b1, 32'h108, 2'd0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    flags(1'b0, 1'b0, "mret"); tick();
    rd(12'h300, 32'h1888, "mret.mstatus"); tick();

    wr(2'd1, 12'hF14, 32'd5); want(SEL_RDATA, 32'h0, "hartid.wrOld");
    flags(1'b1, 1'b1, "hartid.wr"); lastRetire = 1'b0; tick();
    rd(12'h342, 32'd2, "illegal.mcause"); tick();
    rd(12'hF14, 32'h0, "hartid.rd"); flags(1'b0, 1'b0, "hartid.rd"); tick();
    rd(12'h301, 32'h4000_0100, "misa"); tick();
    rd(12'h7C0, 32'h0, "unsup.rdata"); flags(1'b1, 1'b1, "unsup"); lastRetire = 1'b0; tick();

    setMie(); tick();
    irq_timer = 1'b1;
    drive(1'b1, 32'h110, 2'd0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    flags(1'b1, 1'b0, "tmr"); tick();
    irq_timer = 1'b0;
    rd(12'h342, 32'h8000_0007, "tmr.mcause"); tick();

    setMie(); tick();
    irq_timer = 1'b1;
    drive(1'b0, 32'h120, 2'd1, 1'b0, 12'h340, 32'hDEAD, '0, 1'b0, '0, 1'b0, 1'b0);
    flags(1'b0, 1'b0, "stall"); tick();
    irq_timer = 1'b0;
    rd(12'h340, 32'h0, "stall.mscratch"); tick();
    rd(12'h300, 32'h1888, "stall.mstatus"); tick();

    wr(2'd1, 12'h340, 32'h1234); tick();
    drive(1'b1, 32'h200, 2'd3, 1'b1, 12'h340, '0, 5'd4, 1'b0, '0, 1'b0, 1'b0);
    want(SEL_RDATA, 32'h1234, "rc.old"); tick();
    rd(12'h340, 32'h1230, "rc.mscratch"); tick();

    rd(12'hB02, instret[31:0], "minstret"); tick();
    wr(2'd1, 12'hB80, 32'hFFFF_FFFF); tick();
    wr(2'd1, 12'hB00, 32'hFFFF_FFFF); tick();
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle.max"); tick();
    rd(12'hB00, 32'h0, "mcycle.wrapLo"); tick();
    rd(12'hB80, 32'h0, "mcycle.wrapHi"); tick();
    wr(2'd1, 12'hB00, 32'd5); tick();
    rd(12'hB00, 32'd5, "mcycle.wr"); tick();
    rd(12'hB00, 32'd6, "mcycle.inc"); tick();

    rst = 1'b1;
    wr(2'd1, 12'h340, 32'hFFFF); tick();
    rst = 1'b0;
    rd(12'h340, 32'h0, "rstWr.mscratch"); want(SEL_MTVEC, 32'h100, "rstWr.mtvec"); tick();
    rd(12'hB02, instret[31:0], "rstWr.minstret"); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
